// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source and the pwm_capture decoder:
// the raw PWM line plus the period/high-time/duty measurement results.
interface pwm_capture_if #(
   parameter int CNT_W  = 32,
   parameter int DUTY_W = 8
);
   logic              pwm_in;
   logic [CNT_W-1:0]  period;
   logic [CNT_W-1:0]  high_time;
   logic [DUTY_W-1:0] duty;
   logic              valid;
   logic              no_signal;
   logic              overrun;

   modport master (
      output pwm_in,
      input  period, high_time, duty, valid, no_signal, overrun
   );

   modport slave (
      input  pwm_in,
      output period, high_time, duty, valid, no_signal, overrun
   );
endinterface

// File: rtl/pwm_capture.sv
// PWM input decoder: measures period and high time of an asynchronous PWM
// line, derives duty = high*2^DUTY_W/period and flags loss of signal.
module pwm_capture #(
   parameter int CNT_W   = 32,
   parameter int DUTY_W  = 8,
   parameter int TIMEOUT = 50_000_000
) (
   input  logic         clk,
   input  logic         rst_n,
   pwm_capture_if.slave cap
);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam int STEP_W = $clog2(DUTY_W + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DUTY_W - 1);

   typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

   logic [2:0]        sync_reg;
   logic              rise;
   logic              fall;
   logic              edge_seen;
   logic              timeout_hit;

   logic [CNT_W-1:0]  cnt_reg,      cnt_next;
   logic [CNT_W-1:0]  hi_cap_reg,   hi_cap_next;
   logic [CNT_W-1:0]  per_cap_reg,  per_cap_next;
   logic [CNT_W-1:0]  div_hi_reg,   div_hi_next;
   logic [IDLE_W-1:0] idle_reg,     idle_next;
   state_t            state_reg,    state_next;
   logic [STEP_W-1:0] step_reg,     step_next;
   logic [CNT_W-1:0]  rem_reg,      rem_next;
   logic [DUTY_W-1:0] quo_reg,      quo_next;

   logic [CNT_W-1:0]  period_reg,   period_next;
   logic [CNT_W-1:0]  high_reg,     high_next;
   logic [DUTY_W-1:0] duty_reg,     duty_next;
   logic              valid_reg,    valid_next;
   logic              no_signal_reg, no_signal_next;
   logic              overrun_reg,  overrun_next;

   logic [CNT_W:0]    rem_shift;
   logic [CNT_W:0]    trial;
   logic              q_bit;
   logic [CNT_W-1:0]  rem_step;
   logic [DUTY_W-1:0] quo_step;

   // sync_reg[0] = s1, sync_reg[1] = s2, sync_reg[2] = s3
   assign rise        = sync_reg[1] & ~sync_reg[2];
   assign fall        = ~sync_reg[1] & sync_reg[2];
   assign edge_seen   = rise | fall;
   assign timeout_hit = ~edge_seen && (idle_reg == IDLE_LAST);

   // One restoring-division step; the remainder is always below the divisor,
   // so the sign of the trial subtraction alone decides the quotient bit.
   assign rem_shift = {rem_reg, 1'b0};
   assign trial     = rem_shift - {1'b0, per_cap_reg};
   assign q_bit     = ~trial[CNT_W];
   assign rem_step  = q_bit ? trial[CNT_W-1:0] : rem_shift[CNT_W-1:0];
   assign quo_step  = {quo_reg[DUTY_W-2:0], q_bit};

   always_comb begin
      cnt_next    = cnt_reg;
      idle_next   = idle_reg;
      hi_cap_next = hi_cap_reg;

      if (rise)
         cnt_next = CNT_W'(1);
      else if (cnt_reg != '1)
         cnt_next = cnt_reg + CNT_W'(1);

      if (edge_seen)
         idle_next = '0;
      else if (idle_reg != IDLE_MAX)
         idle_next = idle_reg + IDLE_W'(1);

      if (fall)
         hi_cap_next = cnt_reg;
   end

   always_comb begin
      state_next     = state_reg;
      per_cap_next   = per_cap_reg;
      div_hi_next    = div_hi_reg;
      rem_next       = rem_reg;
      quo_next       = quo_reg;
      step_next      = step_reg;
      period_next    = period_reg;
      high_next      = high_reg;
      duty_next      = duty_reg;
      valid_next     = 1'b0;
      no_signal_next = edge_seen ? 1'b0 : no_signal_reg;
      overrun_next   = overrun_reg;

      case (state_reg)
         IDLE: begin
            if (rise)
               state_next = MEASURE;
         end
         MEASURE: begin
            // Divisor and high time are frozen here: a rise or fall arriving
            // during the division must not disturb the result in flight.
            if (rise) begin
               per_cap_next = cnt_reg;
               div_hi_next  = hi_cap_reg;
               rem_next     = hi_cap_reg;
               quo_next     = '0;
               step_next    = '0;
               state_next   = DIVIDE;
            end
         end
         DIVIDE: begin
            rem_next  = rem_step;
            quo_next  = quo_step;
            step_next = step_reg + STEP_W'(1);
            if (rise)
               overrun_next = 1'b1;
            if (step_reg == STEP_LAST) begin
               period_next = per_cap_reg;
               high_next   = div_hi_reg;
               duty_next   = quo_step;
               valid_next  = 1'b1;
               state_next  = MEASURE;
            end
         end
         default: state_next = IDLE;
      endcase

      // Timeout wins over everything, including a division finishing now.
      if (timeout_hit) begin
         state_next     = IDLE;
         valid_next     = 1'b1;
         period_next    = '0;
         high_next      = '0;
         duty_next      = {DUTY_W{sync_reg[1]}};
         no_signal_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg      <= '0;
         cnt_reg       <= '0;
         hi_cap_reg    <= '0;
         per_cap_reg   <= '0;
         div_hi_reg    <= '0;
         idle_reg      <= '0;
         state_reg     <= IDLE;
         step_reg      <= '0;
         rem_reg       <= '0;
         quo_reg       <= '0;
         period_reg    <= '0;
         high_reg      <= '0;
         duty_reg      <= '0;
         valid_reg     <= 1'b0;
         no_signal_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         sync_reg      <= {sync_reg[1:0], cap.pwm_in};
         cnt_reg       <= cnt_next;
         hi_cap_reg    <= hi_cap_next;
         per_cap_reg   <= per_cap_next;
         div_hi_reg    <= div_hi_next;
         idle_reg      <= idle_next;
         state_reg     <= state_next;
         step_reg      <= step_next;
         rem_reg       <= rem_next;
         quo_reg       <= quo_next;
         period_reg    <= period_next;
         high_reg      <= high_next;
         duty_reg      <= duty_next;
         valid_reg     <= valid_next;
         no_signal_reg <= no_signal_next;
         overrun_reg   <= overrun_next;
      end
   end

   assign cap.period    = period_reg;
   assign cap.high_time = high_reg;
   assign cap.duty      = duty_reg;
   assign cap.valid     = valid_reg;
   assign cap.no_signal = no_signal_reg;
   assign cap.overrun   = overrun_reg;
endmodule
